lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the hxd32 decode/ALU datapath and a handshaked data-memory bus.
- Consumes decoded memory controls (load/store enable, funct3 size select, ALU address, rs2 data).
- Issues one bus transaction per memory instruction and stalls PC/register-file update until the data returns.
- Returns sign- or zero-extended load data for the rd write-back mux.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMEOUT, 255, maximum number of cycles to wait for bus_ack_i before aborting; must be at least 1.

Ports:
clk_i  input  1  core clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
mem_rd_en_i  input  1  current instruction is a load
mem_wr_en_i  input  1  current instruction is a store
mem_sel_i  input  3  funct3 size/sign select
addr_i  input  XLEN  effective address (ALU result)
wr_data_i  input  XLEN  store data (rs2)
stall_o  output  1  hold PC and suppress rd write this cycle
rd_data_o  output  XLEN  formatted load data
rd_valid_o  output  1  one-cycle pulse: rd_data_o valid / memory instruction retires
err_o  output  1  one-cycle pulse: bus timeout
bus_req_o  output  1  transaction request, held until ack
bus_we_o  output  1  1 = write
bus_addr_o  output  XLEN  word address, bits [1:0] forced to 0
bus_be_o  output  4  byte-lane enables
bus_wdata_o  output  XLEN  lane-replicated store data
bus_ack_i  input  1  transaction complete, single-cycle pulse
bus_rdata_i  input  XLEN  read data, valid with bus_ack_i

Behaviour:
- Reset is asynchronous and active-low on rst_n_i. Reset values: state IDLE; all outputs 0; timeout counter 0.
- A reset asserted mid-transaction drops bus_req_o immediately. No rd_valid_o or err_o is produced.
- States: IDLE, REQ, DONE.
- stall_o is combinational: 1 when (IDLE and (mem_rd_en_i or mem_wr_en_i)) or state is REQ. It is 0 otherwise, including in DONE.
- IDLE behaviour:
  - On a request, latch bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o and the size select, then move to REQ. bus_req_o goes to 1 the next cycle.
  - If mem_wr_en_i and mem_rd_en_i are both 1, the store wins.
- REQ behaviour:
  - bus_req_o and the bus fields stay stable until bus_ack_i.
  - On bus_ack_i: capture and format bus_rdata_i (loads only), drop bus_req_o, go to DONE.
  - Counter increments every REQ cycle without ack. When it reaches TIMEOUT: drop bus_req_o, set rd_data_o to 0, pulse err_o, go to DONE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as an ack.
- DONE behaviour: rd_valid_o = 1 for exactly one cycle (loads and stores), counter is cleared, go to IDLE. The core advances at the end of this cycle.
- Minimum latency with ack on the first REQ cycle: request seen in cycle 0, bus_req_o in cycle 1, rd_valid_o in cycle 2.
- Back-to-back memory instructions each take the full sequence; no overlap.
- Byte lanes:
  - SB: be = 0001 << addr[1:0].
  - SH: be = 0011 << (addr[1] * 2).
  - SW and any other code: be = 1111.
- Store data: byte replicated to all 4 lanes; halfword replicated to both halves; word unchanged.
- Load format, lane selected by the latched addr[1:0]:
  - 000 sign-extended byte.
  - 001 sign-extended halfword.
  - 100 zero-extended byte.
  - 101 zero-extended halfword.
  - All other codes: full word.
- rd_data_o holds its value until the next load completes.
- Misalignment handling without the optional feature: addr[0] is ignored for halfwords and addr[1:0] is ignored for words. The access is aligned down.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN adds output misalign_o (1 bit, reset 0).
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- When defined: a misaligned request in IDLE goes directly to DONE.
  - No bus transaction is issued.
  - misalign_o pulses with rd_valid_o; rd_data_o is set to 0.
  - stall_o is 1 for one cycle.
- When undefined: the misalign_o port is absent and accesses are aligned down as described above.

Test Plan:
- LB at 0x1003 with bus_rdata_i 0x80FF_0000 and ack on first REQ cycle -> bus_addr_o 0x1000, be 1000, rd_data_o 0xFFFF_FF80, rd_valid_o in cycle 2, stall_o high in cycles 0-1 only.
- SH of 0x1234_ABCD at 0x2002 -> bus_we_o 1, be 1100, bus_wdata_o 0xABCD_ABCD; bus_req_o held through a 5-cycle ack delay.
- LHU at 0x0 with rdata 0x0000_8001 -> rd_data_o 0x0000_8001; LH at 0x2 with rdata 0x8001_0000 -> 0xFFFF_8001.
- No ack with TIMEOUT=4 -> bus_req_o drops after 4 REQ cycles, err_o and rd_valid_o pulse together, rd_data_o 0, next load proceeds normally.
- rst_n_i asserted low during REQ -> bus_req_o and stall_o fall immediately, no rd_valid_o; after release an LW at 0x10 completes normally.
- With LSU_MISALIGN_TRAP_EN, LW at 0x6 -> no bus_req_o, misalign_o and rd_valid_o pulse one cycle after the request; without the macro -> bus_addr_o 0x4, be 1111.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// lsu_ctrl_if: handshaked data-memory bus between lsu_ctrl (master) and memory (slave).
// Rev 1.0
interface lsu_ctrl_if #(
   parameter int XLEN = 32
);
   logic            bus_req_o;
   logic            bus_we_o;
   logic [XLEN-1:0] bus_addr_o;
   logic [3:0]      bus_be_o;
   logic [XLEN-1:0] bus_wdata_o;
   logic            bus_ack_i;
   logic [XLEN-1:0] bus_rdata_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
      input  bus_ack_i, bus_rdata_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
      output bus_ack_i, bus_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// lsu_ctrl: multi-cycle load/store sequencer between the core datapath and a handshaked data bus.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning down. Rev 1.0
module lsu_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            mem_rd_en_i,
   input  logic            mem_wr_en_i,
   input  logic [2:0]      mem_sel_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wr_data_i,
   output logic            stall_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_valid_o,
   output logic            err_o,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic            misalign_o,
`endif
   lsu_ctrl_if.master      bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      sel_q, sel_d;
   logic [1:0]      lo_q, lo_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [XLEN-1:0] rd_data_q, rd_data_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            mem_req;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] fmt;

   assign mem_req = mem_rd_en_i | mem_wr_en_i;
   assign cnt_inc = cnt_q + CW'(1);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misal_q, misal_d;
   logic is_half, is_word, misaligned;
   assign is_half    = (mem_sel_i[1:0] == 2'b01);
   assign is_word    = (mem_sel_i[1:0] != 2'b00) && !is_half;
   assign misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
   assign misalign_o = misal_q;
`endif

   // Lane extraction uses the low address bits captured at request time.
   always_comb begin
      case (lo_q)
         2'd0:    lane_b = bus.bus_rdata_i[7:0];
         2'd1:    lane_b = bus.bus_rdata_i[15:8];
         2'd2:    lane_b = bus.bus_rdata_i[23:16];
         default: lane_b = bus.bus_rdata_i[31:24];
      endcase
      lane_h = lo_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
      case (sel_q)
         3'b000:  fmt = {{(XLEN-8){lane_b[7]}}, lane_b};
         3'b001:  fmt = {{(XLEN-16){lane_h[15]}}, lane_h};
         3'b100:  fmt = {{(XLEN-8){1'b0}}, lane_b};
         3'b101:  fmt = {{(XLEN-16){1'b0}}, lane_h};
         default: fmt = bus.bus_rdata_i;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               we_d   = mem_wr_en_i;
               addr_d = {addr_i[XLEN-1:2], 2'b00};
               sel_d  = mem_sel_i;
               lo_d   = addr_i[1:0];
               case (mem_sel_i[1:0])
                  2'b00: begin
                     be_d    = 4'b0001 << addr_i[1:0];
                     wdata_d = {4{wr_data_i[7:0]}};
                  end
                  2'b01: begin
                     be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                     wdata_d = {2{wr_data_i[15:0]}};
                  end
                  default: begin
                     be_d    = 4'b1111;
                     wdata_d = wr_data_i;
                  end
               endcase
`ifdef LSU_MISALIGN_TRAP_EN
               if (misaligned) begin
                  state_d   = S_DONE;
                  valid_d   = 1'b1;
                  misal_d   = 1'b1;
                  rd_data_d = '0;
               end else
`endif
               begin
                  req_d   = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (bus.bus_ack_i) begin
               req_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_DONE;
               if (!we_q) rd_data_d = fmt;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               req_d     = 1'b0;
               valid_d   = 1'b1;
               err_d     = 1'b1;
               rd_data_d = '0;
               cnt_d     = cnt_inc;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misal_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
         misal_q   <= misal_d;
`endif
      end
   end

   assign stall_o         = ((state_q == S_IDLE) && mem_req) || (state_q == S_REQ);
   assign rd_data_o       = rd_data_q;
   assign rd_valid_o      = valid_q;
   assign err_o           = err_q;
   assign bus.bus_req_o   = req_q;
   assign bus.bus_we_o    = we_q;
   assign bus.bus_addr_o  = addr_q;
   assign bus.bus_be_o    = be_q;
   assign bus.bus_wdata_o = wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// tb_lsu_ctrl: directed table-driven checks of lsu_ctrl plus timeout, reset and misalignment sequences.
module tb_lsu_ctrl;
   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en, wr_en;
   logic [2:0]  sel;
   logic [31:0] addr, wdata;
   logic        stall, rd_valid, err;
   logic [31:0] rd_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   lsu_ctrl_if #(.XLEN(32)) bus_if ();

   lsu_ctrl #(.XLEN(32), .TIMEOUT(TO)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .mem_rd_en_i (rd_en),
      .mem_wr_en_i (wr_en),
      .mem_sel_i   (sel),
      .addr_i      (addr),
      .wr_data_i   (wdata),
      .stall_o     (stall),
      .rd_data_o   (rd_data),
      .rd_valid_o  (rd_valid),
      .err_o       (err),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign_o  (misalign),
`endif
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_wdata;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vt[9];

   logic [31:0] g_addr, g_wdata, g_rd;
   logic [3:0]  g_be;
   logic        g_we, g_err;
   int          g_nreq;

   // One full memory instruction: request cycle, REQ cycles, DONE cycle, one idle cycle.
   task automatic do_txn(input logic rd, input logic wr, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input int delay, input logic give_ack);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; sel = s; addr = a; wdata = wd;
      bus_if.bus_rdata_i = ~rdat;
      #1;
      chk("stall_cycle0", 32'(stall), 32'd1);
      chk("req_cycle0", 32'(bus_if.bus_req_o), 32'd0);
      while (!done && n < 40) begin
         @(posedge clk); #1;
         bus_if.bus_ack_i   = 1'b0;
         bus_if.bus_rdata_i = ~rdat;
         #1;
         if (rd_valid) begin
            done  = 1'b1;
            g_rd  = rd_data;
            g_err = err;
            chk("stall_done", 32'(stall), 32'd0);
            chk("req_done", 32'(bus_if.bus_req_o), 32'd0);
            rd_en = 1'b0;
            wr_en = 1'b0;
         end else begin
            chk("req_held", 32'(bus_if.bus_req_o), 32'd1);
            chk("stall_req", 32'(stall), 32'd1);
            if (n == 0) begin
               g_addr  = bus_if.bus_addr_o;
               g_be    = bus_if.bus_be_o;
               g_we    = bus_if.bus_we_o;
               g_wdata = bus_if.bus_wdata_o;
            end else begin
               chk("addr_stable", bus_if.bus_addr_o, g_addr);
               chk("wdata_stable", bus_if.bus_wdata_o, g_wdata);
            end
            if (give_ack && n == delay) begin
               bus_if.bus_ack_i   = 1'b1;
               bus_if.bus_rdata_i = rdat;
            end
            n++;
         end
      end
      g_nreq = n;
      if (!done) chk("txn_bound_expired", 32'd0, 32'd1);
      @(posedge clk); #2;
      chk("valid_one_cycle", 32'(rd_valid), 32'd0);
      chk("err_one_cycle", 32'(err), 32'd0);
      chk("stall_idle", 32'(stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80};
      vt[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 5, 32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'hFFFF_FF80};
      vt[2] = '{1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_8001, 1, 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h0000_8001};
      vt[3] = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 32'h0000_0000, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001};
      vt[4] = '{1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'h0, 32'h0000_AB00, 2, 32'h0000_0040, 4'b0010, 1'b0, 32'h0, 32'h0000_00AB};
      vt[5] = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 32'h0000_0010, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF};
      vt[6] = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_005A, 32'h0, 1, 32'h0000_0100, 4'b1000, 1'b1, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
      vt[7] = '{1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_1111, 0, 32'h0000_0020, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF};
      vt[8] = '{1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0, 32'h0070_0000, 0, 32'h0000_0000, 4'b0100, 1'b0, 32'h0, 32'h0000_0070};

      rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; sel = 3'b0; addr = '0; wdata = '0;
      bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_req", 32'(bus_if.bus_req_o), 32'd0);
      chk("rst_we", 32'(bus_if.bus_we_o), 32'd0);
      chk("rst_addr", bus_if.bus_addr_o, 32'd0);
      chk("rst_be", 32'(bus_if.bus_be_o), 32'd0);
      chk("rst_wdata", bus_if.bus_wdata_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         do_txn(vt[i].rd, vt[i].wr, vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].delay, 1'b1);
         chk($sformatf("v%0d_addr", i), g_addr, vt[i].e_addr);
         chk($sformatf("v%0d_be", i), 32'(g_be), 32'(vt[i].e_be));
         chk($sformatf("v%0d_we", i), 32'(g_we), 32'(vt[i].e_we));
         chk($sformatf("v%0d_wdata", i), g_wdata, vt[i].e_wdata);
         chk($sformatf("v%0d_rd_data", i), g_rd, vt[i].e_rd);
         chk($sformatf("v%0d_err", i), 32'(g_err), 32'd0);
         chk($sformatf("v%0d_req_cycles", i), 32'(g_nreq), 32'(vt[i].delay + 1));
      end

      // Bus never acks: abort after TO request cycles.
      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'h7777_7777, 0, 1'b0);
      chk("to_req_cycles", 32'(g_nreq), 32'(TO));
      chk("to_err", 32'(g_err), 32'd1);
      chk("to_rd_data", g_rd, 32'd0);
      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 0, 1'b1);
      chk("post_to_rd_data", g_rd, 32'h0BAD_F00D);
      chk("post_to_err", 32'(g_err), 32'd0);

      // Asynchronous reset in the middle of a request.
      @(posedge clk); #1;
      rd_en = 1'b1; sel = 3'b010; addr = 32'h44;
      @(posedge clk); #2;
      chk("mid_req_up", 32'(bus_if.bus_req_o), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0; rd_en = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus_if.bus_req_o), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      repeat (2) begin
         @(posedge clk); #2;
         chk("rst_hold_valid", 32'(rd_valid), 32'd0);
         chk("rst_hold_err", 32'(err), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1357_9BDF, 0, 1'b1);
      chk("post_rst_addr", g_addr, 32'h0000_0010);
      chk("post_rst_rd_data", g_rd, 32'h1357_9BDF);
      chk("post_rst_req_cycles", 32'(g_nreq), 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
      @(posedge clk); #1;
      rd_en = 1'b1; sel = 3'b010; addr = 32'h6;
      #1;
      chk("mis_stall", 32'(stall), 32'd1);
      chk("mis_req0", 32'(bus_if.bus_req_o), 32'd0);
      @(posedge clk); #1;
      rd_en = 1'b0;
      #1;
      chk("mis_valid", 32'(rd_valid), 32'd1);
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_req1", 32'(bus_if.bus_req_o), 32'd0);
      chk("mis_rd_data", rd_data, 32'd0);
      chk("mis_stall_done", 32'(stall), 32'd0);
      @(posedge clk); #2;
      chk("mis_valid_off", 32'(rd_valid), 32'd0);
      chk("mis_flag_off", 32'(misalign), 32'd0);
`else
      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h2468_ACE0, 0, 1'b1);
      chk("mis_addr", g_addr, 32'h0000_0004);
      chk("mis_be", 32'(g_be), 32'hF);
      chk("mis_rd_data", g_rd, 32'h2468_ACE0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
